// File: rtl/oxi_pkg.sv
// Shared types and default thresholds for the multi-channel oximeter front-end controller.
package oxi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CAL_DRIVE,
    CAL_DC,
    CAL_GAIN,
    CAL_NEXT,
    RUN
  } cal_st_e;

  typedef enum logic [1:0] {
    SLOT_START,
    SLOT_ON,
    SLOT_CAPTURE,
    SLOT_GAP
  } slot_ph_e;

  localparam int ADC_LO_DEF = 64;
  localparam int ADC_HI_DEF = 192;

endpackage

// File: rtl/oxi_slot_timer.sv
// Slot phase counter: LED-on from phase 0, ADC capture at SETTLE_CYC, dark gap at SETTLE_CYC+1.
module oxi_slot_timer
  import oxi_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  localparam int PH_W = $clog2(SETTLE_CYC + 2)
) (
  input  logic CLK,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic slot_start,
  output logic capture,
  output logic gap
);

  localparam logic [PH_W-1:0] PH_CAP = PH_W'(SETTLE_CYC);
  localparam logic [PH_W-1:0] PH_GAP = PH_W'(SETTLE_CYC + 1);

  logic [PH_W-1:0] phase;
  slot_ph_e        ph;

  always_ff @(posedge CLK) begin
    if (rst || clr)   phase <= '0;
    else if (en)      phase <= (phase == PH_GAP) ? '0 : phase + 1'b1;
  end

  always_comb begin
    ph = SLOT_ON;
    if (phase == '0)          ph = SLOT_START;
    else if (phase == PH_CAP) ph = SLOT_CAPTURE;
    else if (phase == PH_GAP) ph = SLOT_GAP;
  end

  assign slot_start = en && (ph == SLOT_START);
  assign capture    = en && (ph == SLOT_CAPTURE);
  assign gap        = en && (ph == SLOT_GAP);

endmodule

// File: rtl/oxi_multi_ch_controller.sv
// Time-multiplexed LED front-end controller: per-channel auto-calibration of drive,
// DC compensation and PGA gain, then round-robin sampling of every channel.
module oxi_multi_ch_controller
  import oxi_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int ADC_W      = 8,
  parameter int DRIVE_W    = 4,
  parameter int DC_W       = 7,
  parameter int GAIN_W     = 4,
  parameter int SETTLE_CYC = 4,
  parameter int ADC_LO     = ADC_LO_DEF,
  parameter int ADC_HI     = ADC_HI_DEF,
  parameter int CLK_DIV    = 8,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic [ADC_W-1:0]         ADC,
  input  logic                     Find_setting,
  output logic [NUM_CH-1:0]        LED_EN,
  output logic [DRIVE_W-1:0]       LED_DRIVE,
  output logic [DC_W-1:0]          DC_Comp,
  output logic [GAIN_W-1:0]        PGA_Gain,
  output logic                     CLK_Filter,
  output logic [NUM_CH*ADC_W-1:0]  ADC_Value,
  output logic                     sample_valid,
  output logic [CH_W-1:0]          sample_ch,
  output logic                     cal_busy,
  output logic                     cal_done
);

  localparam int ADC_MID = (ADC_LO + ADC_HI) / 2;
  localparam logic [ADC_W-1:0]   LO_C     = ADC_W'(ADC_LO);
  localparam logic [ADC_W-1:0]   HI_C     = ADC_W'(ADC_HI);
  localparam logic [ADC_W-1:0]   MID_C    = ADC_W'(ADC_MID);
  localparam logic [CH_W-1:0]    CH_LAST  = CH_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0]  CH0_OH   = NUM_CH'(1);
  localparam logic [DRIVE_W-1:0] DRV_MAX  = '1;
  localparam logic [GAIN_W-1:0]  GAIN_MAX = '1;
  localparam logic [DC_W-1:0]    DC_MSB   = DC_W'(1) << (DC_W - 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);

  cal_st_e state;
  logic [CH_W-1:0]    ch, ch_nxt;
  logic [NUM_CH-1:0]  oh_cur, oh_nxt;
  logic               fs_q, fs_q2, start;
  logic [ADC_W-1:0]   smp;

  // working codes of the channel under calibration
  logic [DRIVE_W-1:0] drv;
  logic [DC_W-1:0]    dc, dc_bit, dc_keep;
  logic [GAIN_W-1:0]  gain, gain_fin;

  logic [NUM_CH-1:0][DRIVE_W-1:0] drv_st;
  logic [NUM_CH-1:0][DC_W-1:0]    dc_st;
  logic [NUM_CH-1:0][GAIN_W-1:0]  gain_st;
  logic [NUM_CH-1:0][ADC_W-1:0]   adc_q;

  logic tmr_en, tmr_clr, slot_start, capture, gap;
  logic [DIV_W-1:0] div_cnt;

  assign start    = fs_q && !fs_q2 && !cal_busy;
  assign ch_nxt   = (ch == CH_LAST) ? '0 : ch + 1'b1;
  assign oh_cur   = CH0_OH << ch;
  assign oh_nxt   = CH0_OH << ch_nxt;
  assign dc_keep  = (smp >= MID_C) ? dc : (dc & ~dc_bit);
  assign gain_fin = (smp > HI_C && gain != '0) ? gain - 1'b1 : gain;
  assign tmr_en   = state inside {CAL_DRIVE, CAL_DC, CAL_GAIN, RUN};
  assign tmr_clr  = !tmr_en || start;
  assign ADC_Value = adc_q;

  oxi_slot_timer #(.SETTLE_CYC(SETTLE_CYC)) u_slot (
    .CLK        (CLK),
    .rst        (rst),
    .en         (tmr_en),
    .clr        (tmr_clr),
    .slot_start (slot_start),
    .capture    (capture),
    .gap        (gap)
  );

  always_ff @(posedge CLK) begin
    if (rst) begin
      state        <= IDLE;
      ch           <= '0;
      // a level held high across reset must not look like a fresh edge
      fs_q         <= 1'b1;
      fs_q2        <= 1'b1;
      smp          <= '0;
      drv          <= '0;
      dc           <= '0;
      dc_bit       <= '0;
      gain         <= '0;
      drv_st       <= '0;
      dc_st        <= '0;
      gain_st      <= '0;
      adc_q        <= '0;
      LED_EN       <= '0;
      LED_DRIVE    <= '0;
      DC_Comp      <= '0;
      PGA_Gain     <= '0;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      cal_busy     <= 1'b0;
      cal_done     <= 1'b0;
    end else begin
      fs_q         <= Find_setting;
      fs_q2        <= fs_q;
      sample_valid <= 1'b0;
      if (start) begin
        state     <= CAL_DRIVE;
        ch        <= '0;
        drv       <= '0;
        dc        <= '0;
        dc_bit    <= '0;
        gain      <= '0;
        drv_st    <= '0;
        dc_st     <= '0;
        gain_st   <= '0;
        cal_busy  <= 1'b1;
        cal_done  <= 1'b0;
        LED_EN    <= CH0_OH;
        LED_DRIVE <= '0;
        DC_Comp   <= '0;
        PGA_Gain  <= '0;
      end else begin
        if (capture) begin
          LED_EN <= '0;
          smp    <= ADC;
          if (state == RUN) begin
            adc_q[ch]    <= ADC;
            sample_valid <= 1'b1;
            sample_ch    <= ch;
          end
        end
        unique case (state)
          CAL_DRIVE: if (gap) begin
            LED_EN <= oh_cur;
            if (smp < LO_C && drv != DRV_MAX) begin
              drv       <= drv + 1'b1;
              LED_DRIVE <= drv + 1'b1;
            end else begin
              state   <= CAL_DC;
              dc      <= DC_MSB;
              dc_bit  <= DC_MSB;
              DC_Comp <= DC_MSB;
            end
          end
          CAL_DC: if (gap) begin
            LED_EN <= oh_cur;
            if (dc_bit[0]) begin
              state   <= CAL_GAIN;
              dc      <= dc_keep;
              DC_Comp <= dc_keep;
              gain    <= '0;
              PGA_Gain <= '0;
            end else begin
              dc      <= dc_keep | (dc_bit >> 1);
              DC_Comp <= dc_keep | (dc_bit >> 1);
              dc_bit  <= dc_bit >> 1;
            end
          end
          CAL_GAIN: if (gap) begin
            if (smp <= HI_C && gain != GAIN_MAX) begin
              LED_EN   <= oh_cur;
              gain     <= gain + 1'b1;
              PGA_Gain <= gain + 1'b1;
            end else begin
              // committed on the way into CAL_NEXT so the next slot can read them back
              state       <= CAL_NEXT;
              drv_st[ch]  <= drv;
              dc_st[ch]   <= dc;
              gain_st[ch] <= gain_fin;
            end
          end
          CAL_NEXT: begin
            ch     <= ch_nxt;
            LED_EN <= oh_nxt;
            if (ch == CH_LAST) begin
              state     <= RUN;
              cal_busy  <= 1'b0;
              cal_done  <= 1'b1;
              LED_DRIVE <= drv_st[0];
              DC_Comp   <= dc_st[0];
              PGA_Gain  <= gain_st[0];
            end else begin
              state     <= CAL_DRIVE;
              drv       <= '0;
              dc        <= '0;
              dc_bit    <= '0;
              gain      <= '0;
              LED_DRIVE <= '0;
              DC_Comp   <= '0;
              PGA_Gain  <= '0;
            end
          end
          RUN: if (gap) begin
            ch        <= ch_nxt;
            LED_EN    <= oh_nxt;
            LED_DRIVE <= drv_st[ch_nxt];
            DC_Comp   <= dc_st[ch_nxt];
            PGA_Gain  <= gain_st[ch_nxt];
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      div_cnt    <= '0;
      CLK_Filter <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt    <= '0;
      CLK_Filter <= ~CLK_Filter;
    end else begin
      div_cnt    <= div_cnt + 1'b1;
    end
  end

  // A slot never opens with the LEDs dark.
  a_slot_lit: assert property (@(posedge CLK) disable iff (rst) slot_start |-> (LED_EN != '0));

endmodule
